// File: rtl/mem_wb_stage_if.sv
// Bus between the EX/MEM register, the data memory, the MEM/WB stage and its consumers
// (the GPR file and the ID-stage bypass). The stage itself is the slave side.
interface mem_wb_stage_if;
    // control
    logic        stall;
    logic        flush;
    // EX/MEM slot
    logic        ex_mem_valid;
    logic [31:0] ex_mem_instruction;
    logic [31:0] ex_mem_alu_out;
    logic [31:0] ex_mem_pc;
    logic [1:0]  ex_mem_wb_src;
    logic [1:0]  ex_mem_gpr_w_sel;
    logic [2:0]  ex_mem_load_type;
    logic [31:0] dm_rdata;
    // writeback / bypass
    logic [31:0] mem_wb_instruction;
    logic [1:0]  gpr_w_sel;
    logic [31:0] gpr_w_data;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
    logic        misalign;
    logic [31:0] retired_count;

    modport slave (
        input  stall, flush, ex_mem_valid, ex_mem_instruction, ex_mem_alu_out, ex_mem_pc,
               ex_mem_wb_src, ex_mem_gpr_w_sel, ex_mem_load_type, dm_rdata,
        output mem_wb_instruction, gpr_w_sel, gpr_w_data, fwd_valid, fwd_reg, fwd_data,
               misalign, retired_count
    );

    modport master (
        output stall, flush, ex_mem_valid, ex_mem_instruction, ex_mem_alu_out, ex_mem_pc,
               ex_mem_wb_src, ex_mem_gpr_w_sel, ex_mem_load_type, dm_rdata,
        input  mem_wb_instruction, gpr_w_sel, gpr_w_data, fwd_valid, fwd_reg, fwd_data,
               misalign, retired_count
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback formatter.
// Aligns and extends big-endian load data, selects the writeback value, suppresses
// writes to $0 and misaligned loads, exposes a one-entry bypass and counts retirements.
module mem_wb_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic           clk,
    input  logic           rst,
    mem_wb_stage_if.slave  bus
);
    typedef enum logic [1:0] {
        GPR_NONE = 2'd0,
        GPR_RD   = 2'd1,
        GPR_RT   = 2'd2,
        GPR_RA   = 2'd3
    } gpr_sel_e;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    // pipeline registers
    logic [31:0] instr_q,    instr_d;
    logic [1:0]  sel_q,      sel_d;
    logic [31:0] data_q,     data_d;
    logic        valid_q,    valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] retired_count_q, retired_count_d;
    logic [4:0]  fwd_reg_q,  fwd_reg_d;
    logic [31:0] link_q,     link_d;

    // datapath intermediates
    logic [7:0]  lane [4];
    logic [1:0]  byte_off;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;
    logic [31:0] link_addr;
    logic [31:0] wb_value;
    logic [4:0]  dest;
    logic        load_misalign;
    logic        write_ok;

    // Big-endian byte lanes: lane 0 is the most significant byte of the word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = bus.dm_rdata[31 - 8*gi -: 8];
        end
    endgenerate

    assign byte_off  = bus.ex_mem_alu_out[1:0];
    assign sel_byte  = lane[byte_off];
    assign sel_half  = byte_off[1] ? {lane[2], lane[3]} : {lane[0], lane[1]};
    assign link_addr = bus.ex_mem_pc + 32'd8;

    // Extend the addressed byte/halfword according to the load type.
    always_comb begin
        load_ext = bus.dm_rdata;
        case (bus.ex_mem_load_type)
            LD_LH:   load_ext = {{16{sel_half[15]}}, sel_half};
            LD_LHU:  load_ext = {16'h0000, sel_half};
            LD_LB:   load_ext = {{24{sel_byte[7]}}, sel_byte};
            LD_LBU:  load_ext = {24'h00_0000, sel_byte};
            default: load_ext = bus.dm_rdata;
        endcase
    end

    // Alignment check applies only to instructions that actually write back load data.
    always_comb begin
        load_misalign = 1'b0;
        if (bus.ex_mem_wb_src == WB_LOAD) begin
            case (bus.ex_mem_load_type)
                LD_LH, LD_LHU: load_misalign = byte_off[0];
                LD_LB, LD_LBU: load_misalign = 1'b0;
                default:       load_misalign = (byte_off != 2'b00);
            endcase
        end
    end

    // Writeback source mux and destination decode; reserved source behaves as ALU.
    always_comb begin
        case (bus.ex_mem_wb_src)
            WB_LOAD: wb_value = load_ext;
            WB_LINK: wb_value = link_addr;
            default: wb_value = bus.ex_mem_alu_out;
        endcase
        case (bus.ex_mem_gpr_w_sel)
            GPR_RD:  dest = bus.ex_mem_instruction[15:11];
            GPR_RT:  dest = bus.ex_mem_instruction[20:16];
            GPR_RA:  dest = 5'd31;
            default: dest = 5'd0;
        endcase
        write_ok = (bus.ex_mem_gpr_w_sel != GPR_NONE) && (dest != 5'd0) && !load_misalign;
    end

    // Next-state: flush (or an empty slot) loads a bubble, stall holds, otherwise latch.
    always_comb begin
        instr_d         = instr_q;
        sel_d           = sel_q;
        data_d          = data_q;
        valid_d         = valid_q;
        misalign_d      = misalign_q;
        retired_count_d = retired_count_q;
        fwd_reg_d       = fwd_reg_q;
        link_d          = link_q;
        if (bus.flush || (!bus.stall && !bus.ex_mem_valid)) begin
            instr_d    = 32'h0000_0000;
            sel_d      = GPR_NONE;
            valid_d    = 1'b0;
            misalign_d = 1'b0;
            fwd_reg_d  = 5'd0;
        end else if (!bus.stall) begin
            instr_d         = bus.ex_mem_instruction;
            sel_d           = write_ok ? bus.ex_mem_gpr_w_sel : GPR_NONE;
            data_d          = wb_value;
            valid_d         = 1'b1;
            misalign_d      = load_misalign;
            fwd_reg_d       = write_ok ? dest : 5'd0;
            retired_count_d = retired_count_q + 32'd1;
            if (bus.ex_mem_wb_src == WB_LINK) begin
                link_d = link_addr;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q         <= 32'h0000_0000;
            sel_q           <= GPR_NONE;
            data_q          <= 32'h0000_0000;
            valid_q         <= 1'b0;
            misalign_q      <= 1'b0;
            retired_count_q <= 32'h0000_0000;
            fwd_reg_q       <= 5'd0;
            link_q          <= RESET_PC;
        end else begin
            instr_q         <= instr_d;
            sel_q           <= sel_d;
            data_q          <= data_d;
            valid_q         <= valid_d;
            misalign_q      <= misalign_d;
            retired_count_q <= retired_count_d;
            fwd_reg_q       <= fwd_reg_d;
            link_q          <= link_d;
        end
    end

    assign bus.mem_wb_instruction = instr_q;
    assign bus.gpr_w_sel          = sel_q;
    assign bus.gpr_w_data         = data_q;
    assign bus.fwd_valid          = valid_q && (sel_q != GPR_NONE);
    assign bus.fwd_reg            = fwd_reg_q;
    assign bus.fwd_data           = data_q;
    assign bus.misalign           = misalign_q;
    assign bus.retired_count      = retired_count_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed cases followed by randomized traffic, all
// checked against a behavioural model of the retiring-instruction rules.
module tb_mem_wb_stage;
    logic clk;
    logic rst;
    mem_wb_stage_if bus();

    mem_wb_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    int txn      = 0;

    // model state
    logic [31:0] m_instr;
    logic [1:0]  m_sel;
    logic [31:0] m_data;
    logic        m_data_known;
    logic        m_misalign;
    logic [31:0] m_count;
    logic [4:0]  m_fwd_reg;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Loaded value from the spec's big-endian rules, using byte arithmetic.
    function automatic logic [31:0] model_load(input logic [2:0] lt, input int b, input logic [31:0] w);
        logic [7:0]  bytes [4];
        logic [15:0] half;
        for (int i = 0; i < 4; i++) bytes[i] = 8'((w >> (24 - 8*i)) & 32'hFF);
        half = {bytes[b & 2], bytes[(b & 2) + 1]};
        case (lt)
            3'd1:    return 32'($signed(half));
            3'd2:    return 32'(half);
            3'd3:    return 32'($signed(bytes[b]));
            3'd4:    return 32'(bytes[b]);
            default: return w;
        endcase
    endfunction

    function automatic logic model_misalign(input logic [1:0] src, input logic [2:0] lt, input int b);
        if (src != 2'd1) return 1'b0;
        if (lt == 3'd1 || lt == 3'd2) return (b % 2) != 0;
        if (lt == 3'd3 || lt == 3'd4) return 1'b0;
        return b != 0;
    endfunction

    task automatic compare_all();
        check("instr",     bus.mem_wb_instruction, m_instr);
        check("gpr_w_sel", 32'(bus.gpr_w_sel), 32'(m_sel));
        check("fwd_valid", 32'(bus.fwd_valid), 32'(m_sel != 2'd0));
        check("fwd_reg",   32'(bus.fwd_reg), 32'(m_fwd_reg));
        if (m_data_known) begin
            check("gpr_w_data", bus.gpr_w_data, m_data);
            check("fwd_data",   bus.fwd_data, m_data);
        end
        check("misalign",  32'(bus.misalign), 32'(m_misalign));
        check("count",     bus.retired_count, m_count);
    endtask

    // One clock: advance the model from the current inputs, clock, then compare.
    task automatic tick();
        int          b;
        logic [4:0]  d;
        logic        mis;
        logic        wr;
        logic [31:0] val;
        b = int'(bus.ex_mem_alu_out % 4);
        case (bus.ex_mem_gpr_w_sel)
            2'd1:    d = bus.ex_mem_instruction[15:11];
            2'd2:    d = bus.ex_mem_instruction[20:16];
            2'd3:    d = 5'd31;
            default: d = 5'd0;
        endcase
        mis = model_misalign(bus.ex_mem_wb_src, bus.ex_mem_load_type, b);
        if (bus.ex_mem_wb_src == 2'd1)      val = model_load(bus.ex_mem_load_type, b, bus.dm_rdata);
        else if (bus.ex_mem_wb_src == 2'd2) val = bus.ex_mem_pc + 32'd8;
        else                                val = bus.ex_mem_alu_out;
        wr = (bus.ex_mem_gpr_w_sel != 2'd0) && (d != 5'd0) && !mis;

        @(posedge clk);
        #1;
        if (rst) begin
            m_instr = 0; m_sel = 0; m_data = 0; m_data_known = 1'b1;
            m_misalign = 0; m_count = 0; m_fwd_reg = 0;
        end else if (bus.flush || (!bus.stall && !bus.ex_mem_valid)) begin
            m_instr = 0; m_sel = 0; m_misalign = 0; m_fwd_reg = 0; m_data_known = 1'b0;
        end else if (!bus.stall) begin
            m_instr      = bus.ex_mem_instruction;
            m_sel        = wr ? bus.ex_mem_gpr_w_sel : 2'd0;
            m_fwd_reg    = wr ? d : 5'd0;
            m_data       = val;
            m_data_known = 1'b1;
            m_misalign   = mis;
            m_count      = m_count + 32'd1;
        end
        compare_all();
        $display("txn %0d: rst=%0b stall=%0b flush=%0b valid=%0b sel=%0d data=%h mis=%0b cnt=%0d",
                 txn, rst, bus.stall, bus.flush, bus.ex_mem_valid, bus.gpr_w_sel,
                 bus.gpr_w_data, bus.misalign, bus.retired_count);
        txn++;
    endtask

    task automatic set_in(input logic v, input logic [31:0] instr, input logic [31:0] alu,
                          input logic [31:0] pc, input logic [1:0] src, input logic [1:0] sel,
                          input logic [2:0] lt, input logic [31:0] rdata);
        bus.ex_mem_valid       = v;
        bus.ex_mem_instruction = instr;
        bus.ex_mem_alu_out     = alu;
        bus.ex_mem_pc          = pc;
        bus.ex_mem_wb_src      = src;
        bus.ex_mem_gpr_w_sel   = sel;
        bus.ex_mem_load_type   = lt;
        bus.dm_rdata           = rdata;
    endtask

    localparam logic [31:0] RD_WORD = 32'h80F1_7F02;
    localparam logic [31:0] LD_RT5  = 32'h8005_0000;

    initial begin
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        set_in(1'b1, 32'hDEAD_BEEF, 32'h5555_0001, 32'h100, 2'd0, 2'd1, 3'd0, 32'h0);
        m_instr = 0; m_sel = 0; m_data = 0; m_data_known = 1'b1;
        m_misalign = 0; m_count = 0; m_fwd_reg = 0;

        // reset held two cycles
        tick();
        tick();
        check("rst_count", bus.retired_count, 32'h0);
        check("rst_data",  bus.gpr_w_data, 32'h0);
        rst = 1'b0;

        // addu $3
        set_in(1'b1, 32'h0000_1821, 32'h0000_1234, 32'h3000, 2'd0, 2'd1, 3'd0, 32'h0);
        tick();
        check("addu_data", bus.gpr_w_data, 32'h0000_1234);
        check("addu_reg",  32'(bus.fwd_reg), 32'd3);
        check("addu_cnt",  bus.retired_count, 32'd1);

        // loads into $5
        set_in(1'b1, LD_RT5, 32'h1000, 32'h3004, 2'd1, 2'd2, 3'd3, RD_WORD); tick();
        check("lb_b0",  bus.gpr_w_data, 32'hFFFF_FF80);
        set_in(1'b1, LD_RT5, 32'h1001, 32'h3008, 2'd1, 2'd2, 3'd4, RD_WORD); tick();
        check("lbu_b1", bus.gpr_w_data, 32'h0000_00F1);
        set_in(1'b1, LD_RT5, 32'h1002, 32'h300C, 2'd1, 2'd2, 3'd1, RD_WORD); tick();
        check("lh_b2",  bus.gpr_w_data, 32'h0000_7F02);
        set_in(1'b1, LD_RT5, 32'h1000, 32'h3010, 2'd1, 2'd2, 3'd2, RD_WORD); tick();
        check("lhu_b0", bus.gpr_w_data, 32'h0000_80F1);

        // misaligned LW and LH
        set_in(1'b1, LD_RT5, 32'h1002, 32'h3014, 2'd1, 2'd2, 3'd0, RD_WORD); tick();
        check("lw_mis",     32'(bus.misalign), 32'd1);
        check("lw_mis_sel", 32'(bus.gpr_w_sel), 32'd0);
        check("lw_mis_cnt", bus.retired_count, 32'd6);
        set_in(1'b1, LD_RT5, 32'h1001, 32'h3018, 2'd1, 2'd2, 3'd1, RD_WORD); tick();
        check("lh_mis",     32'(bus.misalign), 32'd1);
        check("lh_mis_cnt", bus.retired_count, 32'd7);

        // jal link and $0 destination
        set_in(1'b1, 32'h0C00_0000, 32'h0, 32'h3010, 2'd2, 2'd3, 3'd0, 32'h0); tick();
        check("jal_data", bus.gpr_w_data, 32'h0000_3018);
        check("jal_reg",  32'(bus.fwd_reg), 32'd31);
        set_in(1'b1, 32'h0000_0021, 32'h77, 32'h3014, 2'd0, 2'd1, 3'd0, 32'h0); tick();
        check("rd0_sel",   32'(bus.gpr_w_sel), 32'd0);
        check("rd0_valid", 32'(bus.fwd_valid), 32'd0);

        // three-cycle stall, then release
        set_in(1'b1, 32'h0000_2021, 32'hABCD, 32'h3018, 2'd0, 2'd1, 3'd0, 32'h0);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_cnt", bus.retired_count, 32'd9);
        end
        bus.stall = 1'b0;
        tick();
        check("unstall_reg", 32'(bus.fwd_reg), 32'd4);

        // flush and stall together
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        tick();
        check("flush_instr", bus.mem_wb_instruction, 32'h0);
        check("flush_cnt",   bus.retired_count, 32'd10);
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        // counter wrap
        force dut.retired_count_q = 32'hFFFF_FFFF;
        #2;
        release dut.retired_count_q;
        m_count = 32'hFFFF_FFFF;
        check("preload", bus.retired_count, 32'hFFFF_FFFF);
        tick();
        check("wrap", bus.retired_count, 32'h0);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            bus.stall = ($urandom_range(0, 4) == 0);
            bus.flush = ($urandom_range(0, 7) == 0);
            set_in($urandom_range(0, 3) != 0, $urandom(),
                   {$urandom_range(0, 1) == 0 ? 30'($urandom()) : 30'h0, 2'($urandom_range(0, 3))},
                   $urandom(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   3'($urandom_range(0, 7)), $urandom());
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
